// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and UART-transmitter signal bundle for uart_tx_arbiter.
//   req       requester -> arbiter  per-requester request, held until own gnt bit seen
//   req_data  requester -> arbiter  byte of requester i at [i*DATA_W +: DATA_W]
//   gnt       arbiter -> requester  one-hot pulse, byte captured
//   done      arbiter -> requester  one-hot pulse, byte transmitted
//   err       arbiter -> requester  one-hot pulse, transfer aborted by watchdog
//   tx_start  arbiter -> UART       one-cycle start pulse
//   tx_data   arbiter -> UART       byte to send
//   tx_done   UART -> arbiter       transmit-complete pulse
//   busy      arbiter -> observer   high while a transfer is in flight
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        done;
   logic [NUM_REQ-1:0]        err;
   logic                      tx_start;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_done;
   logic                      busy;
   modport slave  (input req, req_data, tx_done, output gnt, done, err, tx_start, tx_data, busy);
   modport master (output req, req_data, tx_done, input gnt, done, err, tx_start, tx_data, busy);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte producers.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  uart_tx_arbiter_if slave modport (requester handshake and UART tx_start/tx_data/tx_done)
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 16384
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t             state_q, state_d;
   logic [IDX_W-1:0]   cur_q, cur_d, last_q, last_d, pick, cand;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
   logic               tx_start_q, tx_start_d, busy_q, busy_d, found;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.busy     = busy_q;
   // Scan starts just after the last served requester and wraps, so a
   // requester that keeps its req high after completion yields to the others.
   always_comb begin
      found = 1'b0;
      pick  = last_q;
      cand  = last_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      last_d     = last_q;
      wd_d       = wd_q;
      tx_data_d  = tx_data_q;
      gnt_d      = '0;
      done_d     = '0;
      err_d      = '0;
      tx_start_d = 1'b0;
      busy_d     = 1'b0;
      case (state_q)
         IDLE: if (found) begin
            state_d    = ISSUE;
            cur_d      = pick;
            tx_data_d  = bus.req_data[int'(pick)*DATA_W +: DATA_W];
            gnt_d      = NUM_REQ'(1) << pick;
            tx_start_d = 1'b1;
            busy_d     = 1'b1;
         end
         ISSUE: begin
            state_d = WAIT;
            wd_d    = '0;
            busy_d  = 1'b1;
         end
         WAIT: begin
            busy_d = 1'b1;
            wd_d   = (wd_q == {WD_W{1'b1}}) ? wd_q : wd_q + WD_W'(1);
            // tx_done is checked first so it wins over a coincident timeout.
            if (bus.tx_done) begin
               state_d = IDLE;
               done_d  = NUM_REQ'(1) << cur_q;
               last_d  = cur_q;
               busy_d  = 1'b0;
               wd_d    = '0;
            end else if (TIMEOUT_CYC != 0 && wd_q == WD_MAX) begin
               state_d = IDLE;
               err_d   = NUM_REQ'(1) << cur_q;
               last_d  = cur_q;
               busy_d  = 1'b0;
               wd_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         last_q     <= IDX_W'(NUM_REQ - 1);
         wd_q       <= '0;
         tx_data_q  <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         err_q      <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         last_q     <= last_d;
         wd_q       <= wd_d;
         tx_data_q  <= tx_data_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
      end
   end
endmodule
